// File: rtl/voice_scheduler.sv
// Time-multiplexes one waveform lookup unit across NUM_VOICES tone voices and mixes the
// volume-scaled results into one signed sample per request. Holds the per-voice register file.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              sample_req_in,
    input  logic              reg_we_in,
    input  logic [ADDR_W-1:0] reg_addr_in,
    input  logic [7:0]        reg_data_in,
    output logic              wg_valid_out,
    input  logic              wg_ready_in,
    output logic [7:0]        wg_phase_out,
    output logic [3:0]        wg_voice_out,
    input  logic              wg_result_valid_in,
    input  logic [7:0]        wg_result_in,
    output logic [15:0]       sample_out,
    output logic              sample_valid_out,
    output logic              busy_out,
    output logic              overrun_out
);

    typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StMix, StDone} state_e;

    state_e state_q, state_d;

    logic [15:0] freq_q  [NUM_VOICES];
    logic [15:0] freq_d  [NUM_VOICES];
    logic [15:0] phase_q [NUM_VOICES];
    logic [15:0] phase_d [NUM_VOICES];
    logic [3:0]  vol_q   [NUM_VOICES];
    logic [3:0]  vol_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_d;

    logic [3:0]         voice_q, voice_d;
    logic [15:0]        phase_next_q, phase_next_d;
    logic [3:0]         cur_vol_q, cur_vol_d;
    logic [7:0]         wave_q, wave_d;
    logic signed [15:0] acc_q, acc_d;
    logic [15:0]        sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               pending_q, pending_d;

    logic [15:0]        sel_freq, sel_phase;
    logic [3:0]         sel_vol;
    logic               sel_en;
    logic               consume;
    logic [3:0]         wr_voice;
    logic [1:0]         wr_field;
    logic signed [12:0] wave_ext, vol_ext, prod;

    assign wr_voice = reg_addr_in[5:2];
    assign wr_field = reg_addr_in[1:0];
    assign consume  = (state_q == StIdle) && pending_q;

    // Volume is unsigned 0..15, so it is zero-extended before the signed multiply.
    assign wave_ext = {{5{wave_q[7]}}, wave_q};
    assign vol_ext  = {9'd0, cur_vol_q};
    assign prod     = wave_ext * vol_ext;

    always_comb begin
        sel_freq  = '0;
        sel_phase = '0;
        sel_vol   = '0;
        sel_en    = 1'b0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (voice_q == 4'(i)) begin
                sel_freq  = freq_q[i];
                sel_phase = phase_q[i];
                sel_vol   = vol_q[i];
                sel_en    = en_q[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        freq_d         = freq_q;
        phase_d        = phase_q;
        vol_d          = vol_q;
        en_d           = en_q;
        voice_d        = voice_q;
        phase_next_d   = phase_next_q;
        cur_vol_d      = cur_vol_q;
        wave_d         = wave_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        pending_d      = pending_q;

        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (reg_we_in && (wr_voice == 4'(i))) begin
                unique case (wr_field)
                    2'd0:    freq_d[i][7:0]  = reg_data_in;
                    2'd1:    freq_d[i][15:8] = reg_data_in;
                    2'd2: begin
                        vol_d[i] = reg_data_in[3:0];
                        en_d[i]  = reg_data_in[7];
                    end
                    default: ;
                endcase
            end
        end

        // A request landing on the consume cycle simply re-arms the latch.
        if (consume) begin
            pending_d = 1'b0;
        end
        if (sample_req_in) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    voice_d = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!sel_en) begin
                    wave_d    = '0;
                    cur_vol_d = '0;
                    state_d   = StMix;
                end else begin
                    phase_next_d = sel_phase + sel_freq;
                    cur_vol_d    = sel_vol;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (wg_ready_in) begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (voice_q == 4'(i)) begin
                            phase_d[i] = phase_next_q;
                        end
                    end
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wg_result_valid_in) begin
                    wave_d  = wg_result_in;
                    state_d = StMix;
                end
            end
            StMix: begin
                acc_d = acc_q + {{3{prod[12]}}, prod};
                if (voice_q == 4'(NUM_VOICES - 1)) begin
                    state_d = StDone;
                end else begin
                    voice_d = voice_q + 4'd1;
                    state_d = StCheck;
                end
            end
            StDone: begin
                sample_d       = acc_q;
                sample_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
                vol_q[i]   <= '0;
            end
            en_q           <= '0;
            voice_q        <= '0;
            phase_next_q   <= '0;
            cur_vol_q      <= '0;
            wave_q         <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            freq_q         <= freq_d;
            phase_q        <= phase_d;
            vol_q          <= vol_d;
            en_q           <= en_d;
            voice_q        <= voice_d;
            phase_next_q   <= phase_next_d;
            cur_vol_q      <= cur_vol_d;
            wave_q         <= wave_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            pending_q      <= pending_d;
        end
    end

    assign wg_valid_out     = (state_q == StIssue);
    assign wg_phase_out     = phase_next_q[15:8];
    assign wg_voice_out     = voice_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = sample_valid_q;
    assign busy_out         = busy_q;
    assign overrun_out      = overrun_q;

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Time-multiplexes one shared waveform-generation datapath among NUM_VOICES tone voices.
- Once per audio sample request from the I2S serializer side, steps through the voices in order. For each enabled voice it advances that voice's phase accumulator and issues one lookup to the shared waveform unit. It then scales the returned sample by the voice volume and mixes it into one signed sample word.
- Holds the SPI-written per-voice register file (frequency, volume, enable).
- Sits between the SPI register decoder, the waveform unit and the I2S output stage inside the tone engine.

Parameters:
- NUM_VOICES, 4, number of time-multiplexed voices; legal range 1..16.
- ADDR_W, 6, register address width: addr[5:2] = voice index, addr[1:0] = field.

Ports:
- clk_in  input  1  single system clock.
- reset_in  input  1  synchronous, active-high reset.
- sample_req_in  input  1  one-cycle pulse requesting the next output sample.
- reg_we_in  input  1  register write strobe from the SPI decoder.
- reg_addr_in  input  ADDR_W  register address.
- reg_data_in  input  8  register write data.
- wg_valid_out  output  1  lookup request to the waveform unit.
- wg_ready_in  input  1  waveform unit accepts the request.
- wg_phase_out  output  8  phase index, equal to phase_next[15:8].
- wg_voice_out  output  4  index of the voice being serviced.
- wg_result_valid_in  input  1  waveform result strobe.
- wg_result_in  input  8  signed waveform sample.
- sample_out  output  16  signed mixed sample; holds its value between frames.
- sample_valid_out  output  1  one-cycle pulse when sample_out updates.
- busy_out  output  1  high while a frame is in progress.
- overrun_out  output  1  sticky flag: a request was lost.

Behaviour:
- Reset (synchronous):
  - All outputs go to 0.
  - All phase accumulators, frequencies, volumes and enables go to 0.
  - The pending-request latch clears and the FSM goes to IDLE.
  - Reset asserted mid-frame abandons the frame: no sample_valid_out pulse, and wg_valid_out drops the next cycle.
- Register fields, per voice v, written on any cycle with reg_we_in=1:
  - Field 0: freq[7:0].
  - Field 1: freq[15:8].
  - Field 2: vol = data[3:0], en = data[7].
  - Field 3: ignored.
  - Writes with voice index >= NUM_VOICES are ignored.
- Write/issue collision: a write that coincides with the issue of the same voice updates the register. The in-flight operation uses the value captured at ISSUE entry, so the new value applies from the next frame.
- Request latching:
  - sample_req_in sets a pending latch.
  - If the latch is already set when a new request arrives, overrun_out sets (sticky until reset) and the extra request is dropped.
  - A request arriving in the same cycle the FSM consumes the latch re-sets it and is not an overrun.
- FSM states: IDLE, CHECK, ISSUE, WAIT, MIX, DONE.
  - IDLE: when pending=1, clear pending, set voice index to 0, clear the accumulator, set busy_out=1, go to CHECK.
  - CHECK: if en[v]=0, go to MIX with contribution 0; the phase is not advanced. Otherwise compute phase_next = phase[v] + freq[v] mod 2^16 and go to ISSUE.
  - ISSUE: assert wg_valid_out, wg_phase_out and wg_voice_out, and hold them stable until wg_ready_in=1. On the handshake cycle, write phase_next to phase[v] and go to WAIT.
  - WAIT: on wg_result_valid_in=1, capture wg_result_in and go to MIX. A result strobe outside WAIT is ignored.
  - MIX: acc += sign-extended wave × vol. The product is signed 12-bit; acc is signed 16-bit, and no overflow is possible for NUM_VOICES <= 16. If v = NUM_VOICES-1 go to DONE, else increment v and go to CHECK.
  - DONE: sample_out <= acc, pulse sample_valid_out, clear busy_out, go to IDLE.
- Only one waveform request is outstanding at a time.
- Latency:
  - With all voices disabled: exactly 2×NUM_VOICES+3 cycles from the request pulse to sample_valid_out.
  - With the waveform unit at zero wait (ready immediately, result the cycle after the handshake): 4×NUM_VOICES+3 cycles.

Test Plan:
- Reset then request, all voices disabled -> sample_valid_out pulses 11 cycles after the request (NUM_VOICES=4), sample_out=0x0000, wg_valid_out never asserted.
- Voice 0 set to freq=0x0100, vol=15, en=1; waveform model returns +100; three requests -> wg_phase_out = 0x01, 0x02, 0x03, sample_out = 1500 (0x05DC) each frame.
- All 4 voices set to vol=15 with the model returning -128 -> sample_out = -7680 (0xE200). Voice 1 freq=0xFFFF, so its phase wraps 0xFFFF→0xFFFE with no error.
- wg_ready_in held low 5 cycles -> wg_valid_out, wg_phase_out and wg_voice_out stay stable and the phase commits only on the handshake. A freq write to the in-flight voice during the stall takes effect the next frame.
- Two sample_req_in pulses while busy -> the first is latched and served, the second sets overrun_out=1, which remains 1 until reset_in.
- reset_in asserted while in WAIT -> the next cycle has busy_out=0 and wg_valid_out=0, no sample_valid_out pulse, and all registers read back as zero behaviour.
